// File: rtl/mul_arbiter_if.sv
// Requester/multiplier bundle around the shared-multiplier arbiter.
// The slave view is the arbiter; the master view is everything around it.
interface mul_arbiter_if #(
  parameter int N       = 4,
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]     req_i;
  logic [NUM_REQ*2*N-1:0] a_i;
  logic [NUM_REQ*2*N-1:0] b_i;
  logic [NUM_REQ-1:0]     ack_o;
  logic [2*N-1:0]         result_o;
  logic                   err_o;
  logic                   busy_o;
  logic                   mul_start_strb_o;
  logic [2*N-1:0]         mul_a_o;
  logic [2*N-1:0]         mul_b_o;
  logic                   mul_done_strb_i;
  logic [2*N-1:0]         mul_out_i;

  modport slave (
    input  req_i, a_i, b_i, mul_done_strb_i, mul_out_i,
    output ack_o, result_o, err_o, busy_o, mul_start_strb_o, mul_a_o, mul_b_o
  );

  modport master (
    output req_i, a_i, b_i, mul_done_strb_i, mul_out_i,
    input  ack_o, result_o, err_o, busy_o, mul_start_strb_o, mul_a_o, mul_b_o
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential signed multiplier among NUM_REQ requesters.
// IDLE->START->WAIT->DONE per job; a watchdog aborts jobs whose done strobe never arrives.
module mul_arbiter #(
  parameter int N       = 4,
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  mul_arbiter_if.slave arb
);
  localparam int W  = 2 * N;
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state_q;
  logic [GW-1:0]      rr_q;
  logic [GW-1:0]      grant_q;
  logic [TW-1:0]      timer_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [W-1:0]       result_q;
  logic [W-1:0]       mul_a_q;
  logic [W-1:0]       mul_b_q;
  logic               err_q;
  logic               busy_q;
  logic               start_q;

  logic [GW-1:0]      pick_d;
  logic               any_d;
  logic [W-1:0]       a_sel_d;
  logic [W-1:0]       b_sel_d;

  function automatic logic [GW-1:0] wrap_idx(input int v);
    return GW'(v % NUM_REQ);
  endfunction

  // Scan downward so the lowest offset from the pointer is written last and wins.
  always_comb begin
    pick_d = '0;
    any_d  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (arb.req_i[wrap_idx(int'(rr_q) + i)]) begin
        pick_d = wrap_idx(int'(rr_q) + i);
        any_d  = 1'b1;
      end
    end
  end

  always_comb begin
    a_sel_d = '0;
    b_sel_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_d == GW'(k)) begin
        a_sel_d = arb.a_i[k*W +: W];
        b_sel_d = arb.b_i[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      timer_q  <= '0;
      ack_q    <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      ack_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_d) begin
            grant_q <= pick_d;
            mul_a_q <= a_sel_d;
            mul_b_q <= b_sel_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          timer_q <= timer_q + 1'b1;
          // A done strobe arriving on the last allowed cycle still counts as success.
          if (arb.mul_done_strb_i) begin
            result_q <= arb.mul_out_i;
            ack_q    <= NUM_REQ'(1) << grant_q;
            state_q  <= DONE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            ack_q    <= NUM_REQ'(1) << grant_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          rr_q    <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.ack_o            = ack_q;
  assign arb.result_o         = result_q;
  assign arb.err_o            = err_q;
  assign arb.busy_o           = busy_q;
  assign arb.mul_start_strb_o = start_q;
  assign arb.mul_a_o          = mul_a_q;
  assign arb.mul_b_o          = mul_b_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: u_big (TIMEOUT=1024) for arbitration and reset cases,
// u_wd (TIMEOUT=16) for watchdog cases; each has its own behavioural multiplier.
module tb_mul_arbiter;
  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bad_ack = 0;
  int   n_start_b = 0;
  int   n_start_w = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_arbiter_if #(.N(4), .NUM_REQ(3)) ifb ();
  mul_arbiter_if #(.N(4), .NUM_REQ(3)) ifw ();

  mul_arbiter #(.N(4), .NUM_REQ(3), .TIMEOUT(1024)) u_big (
    .clk_i (clk), .rstn_i (rstn), .arb (ifb.slave));
  mul_arbiter #(.N(4), .NUM_REQ(3), .TIMEOUT(16)) u_wd (
    .clk_i (clk), .rstn_i (rstn), .arb (ifw.slave));

  // Behavioural multipliers: done strobe and truncated product lat cycles after start.
  int         lat_b = 20;
  int         cnt_b = -1;
  logic       mdl_done_b = 1'b0;
  logic [7:0] mdl_out_b = '0, opa_b = '0, opb_b = '0;
  logic       tb_done_b;
  logic [7:0] tb_out_b;

  int         lat_w = 5;
  bit         mute_w = 1'b0;
  int         cnt_w = -1;
  logic       mdl_done_w = 1'b0;
  logic [7:0] mdl_out_w = '0, opa_w = '0, opb_w = '0;

  assign ifb.mul_done_strb_i = mdl_done_b | tb_done_b;
  assign ifb.mul_out_i       = tb_done_b ? tb_out_b : mdl_out_b;
  assign ifw.mul_done_strb_i = mdl_done_w;
  assign ifw.mul_out_i       = mdl_out_w;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_b = -1;
      mdl_done_b = 1'b0;
    end else begin
      #1;
      mdl_done_b = 1'b0;
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) begin
          mdl_done_b = 1'b1;
          mdl_out_b  = opa_b * opb_b;
          cnt_b      = -1;
        end
      end
      if (ifb.mul_start_strb_o) begin
        cnt_b = lat_b; opa_b = ifb.mul_a_o; opb_b = ifb.mul_b_o;
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_w = -1;
      mdl_done_w = 1'b0;
    end else begin
      #1;
      mdl_done_w = 1'b0;
      if (cnt_w > 0) begin
        cnt_w--;
        if (cnt_w == 0) begin
          mdl_done_w = 1'b1;
          mdl_out_w  = opa_w * opb_w;
          cnt_w      = -1;
        end
      end
      if (ifw.mul_start_strb_o && !mute_w) begin
        cnt_w = lat_w; opa_w = ifw.mul_a_o; opb_w = ifw.mul_b_o;
      end
    end
  end

  always @(negedge clk) begin
    if ($countones(ifb.ack_o) > 1 || $countones(ifw.ack_o) > 1) bad_ack++;
    if (ifb.mul_start_strb_o) n_start_b++;
    if (ifw.mul_start_strb_o) n_start_w++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic no_resp(input string tag, input int budget);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response within %0d cycles, got none expected one", tag, budget);
  endtask

  task automatic wait_start(input bit wd, input int budget, output int s);
    s = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (wd ? ifw.mul_start_strb_o : ifb.mul_start_strb_o) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) no_resp(wd ? "wd_start" : "start", budget);
  endtask

  task automatic wait_ack(input bit wd, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if ((wd ? ifw.ack_o : ifb.ack_o) != '0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) no_resp(wd ? "wd_ack" : "ack", budget);
  endtask

  task automatic run_job(input bit wd, input logic [2:0] r, output int s, output int at);
    if (wd) ifw.req_i = r; else ifb.req_i = r;
    wait_start(wd, 10, s);
    wait_ack(wd, 40, at);
    if (wd) ifw.req_i = '0; else ifb.req_i = '0;
  endtask

  initial begin
    int s, at, rq;
    logic [7:0] e;
    rstn = 1'b1;
    ifb.req_i = '0; ifb.a_i = '0; ifb.b_i = '0;
    ifw.req_i = '0; ifw.a_i = '0; ifw.b_i = '0;
    tb_done_b = 1'b0; tb_out_b = '0;
    #3 rstn = 1'b0;
    #1;
    chk("rst_busy", ifb.busy_o, 0);
    chk("rst_ack", ifb.ack_o, 0);
    chk("rst_result", ifb.result_o, 0);
    chk("rst_err", ifb.err_o, 0);
    chk("rst_strb", ifb.mul_start_strb_o, 0);
    chk("rst_mul_a", ifb.mul_a_o, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Fairness: pointer starts at 0, all three held.
    for (int k = 0; k < 3; k++) begin
      ifb.a_i[k*8 +: 8] = 8'(k + 1);
      ifb.b_i[k*8 +: 8] = 8'hFE;
    end
    ifb.req_i = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, 40, at);
      e = 8'(-2 * (i % 3 + 1));
      chk("fair_ack", ifb.ack_o, 3'b001 << (i % 3));
      chk("fair_result", ifb.result_o, e);
      chk("fair_err", ifb.err_o, 0);
    end
    ifb.req_i = 3'b000;

    // Rotation: pointer is 1 after the last grant to 0, so 2 leads, then 0, alternating.
    ifb.req_i = 3'b101;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, 40, at);
      chk("rot_ack", ifb.ack_o, (i % 2 == 0) ? 3'b100 : 3'b001);
      chk("rot_result", ifb.result_o, (i % 2 == 0) ? 8'hFA : 8'hFE);
    end
    ifb.req_i = 3'b000;

    // Single job 3*5, L=20.
    repeat (2) @(posedge clk); #1;
    ifb.a_i[7:0] = 8'd3; ifb.b_i[7:0] = 8'd5;
    rq = cyc;
    ifb.req_i = 3'b001;
    wait_start(0, 10, s);
    chk("t1_req_to_start", s - rq, 1);
    chk("t1_mul_a", ifb.mul_a_o, 3);
    chk("t1_mul_b", ifb.mul_b_o, 5);
    wait_ack(0, 40, at);
    ifb.req_i = 3'b000;
    chk("t1_ack", ifb.ack_o, 3'b001);
    chk("t1_result", ifb.result_o, 15);
    chk("t1_err", ifb.err_o, 0);
    chk("t1_start_to_ack", at - s, 21);
    @(posedge clk); #1;
    chk("t1_busy_after", ifb.busy_o, 0);
    chk("t1_ack_pulse", ifb.ack_o, 0);

    // Spurious done while idle.
    tb_out_b = 8'h55; tb_done_b = 1'b1;
    @(posedge clk); #1 tb_done_b = 1'b0;
    for (int j = 0; j < 2; j++) begin
      chk("spur_ack", ifb.ack_o, 0);
      chk("spur_result", ifb.result_o, 15);
      @(posedge clk); #1;
    end

    // Signed passthrough: -128 * -1 truncates to 8'h80.
    ifb.a_i[7:0] = 8'h80; ifb.b_i[7:0] = 8'hFF;
    run_job(0, 3'b001, s, at);
    chk("pass_ack", ifb.ack_o, 3'b001);
    chk("pass_result", ifb.result_o, 8'h80);
    chk("pass_err", ifb.err_o, 0);

    // Watchdog DUT: normal, aborted, then done on the abort cycle.
    ifw.a_i[7:0] = 8'd2; ifw.b_i[7:0] = 8'd3;
    lat_w = 5;
    run_job(1, 3'b001, s, at);
    chk("wdA_result", ifw.result_o, 6);
    chk("wdA_err", ifw.err_o, 0);
    chk("wdA_lat", at - s, 6);
    mute_w = 1'b1;
    run_job(1, 3'b001, s, at);
    chk("wdB_ack", ifw.ack_o, 3'b001);
    chk("wdB_err", ifw.err_o, 1);
    chk("wdB_result", ifw.result_o, 0);
    chk("wdB_lat", at - s, 17);
    @(posedge clk); #1;
    chk("wdB_err_pulse", ifw.err_o, 0);
    mute_w = 1'b0; lat_w = 16;
    ifw.a_i[7:0] = 8'hFD; ifw.b_i[7:0] = 8'd7;
    run_job(1, 3'b001, s, at);
    chk("wdC_err", ifw.err_o, 0);
    chk("wdC_result", ifw.result_o, 8'hEB);
    chk("wdC_lat", at - s, 17);

    // Reset while waiting on the multiplier.
    ifb.a_i[7:0] = 8'd3; ifb.b_i[7:0] = 8'd5;
    ifb.req_i = 3'b001;
    wait_start(0, 10, s);
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", ifb.busy_o, 0);
    chk("mid_rst_result", ifb.result_o, 0);
    chk("mid_rst_mul_a", ifb.mul_a_o, 0);
    chk("mid_rst_mul_b", ifb.mul_b_o, 0);
    chk("mid_rst_ack", ifb.ack_o, 0);
    ifb.req_i = 3'b000;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    tb_out_b = 8'h77; tb_done_b = 1'b1;
    @(posedge clk); #1 tb_done_b = 1'b0;
    chk("late_done_ack", ifb.ack_o, 0);
    chk("late_done_result", ifb.result_o, 0);
    chk("late_done_busy", ifb.busy_o, 0);
    ifb.a_i[15:8] = 8'd4; ifb.b_i[15:8] = 8'd4;
    run_job(0, 3'b010, s, at);
    chk("post_rst_ack", ifb.ack_o, 3'b010);
    chk("post_rst_result", ifb.result_o, 16);
    chk("post_rst_err", ifb.err_o, 0);

    repeat (2) @(posedge clk); #1;
    chk("ack_onehot", bad_ack, 0);
    chk("starts_big", n_start_b, 12);
    chk("starts_wd", n_start_w, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
